// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - shared types and default parameters for the FIFO drain controller
package fifo_drain_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } drain_state_t;

    localparam int DATA_WIDTH_D  = 8;
    localparam int BUF_DEPTH_D   = 2;
    localparam int ACK_TIMEOUT_D = 4;
    localparam int CNT_WIDTH_D   = 16;

endpackage

// File: rtl/drain_out_buf.sv
// rtl/drain_out_buf.sv - circular valid/ready output buffer fed by the drain FSM
module drain_out_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  pop,
    output logic                  full
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign valid = (count != '0);
    assign data  = mem[rd_ptr];
    assign pop   = valid & ready;
    assign full  = (count == CW'(BUF_DEPTH));

endmodule

// File: rtl/fifo_drain_ctrl.sv
// rtl/fifo_drain_ctrl.sv - read-side master that drains the async FIFO into a valid/ready stream
module fifo_drain_ctrl
    import fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_D,
    parameter int BUF_DEPTH   = BUF_DEPTH_D,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_D,
    parameter int CNT_WIDTH   = CNT_WIDTH_D
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  clr_stats,
    input  logic                  fifo_empty,
    input  logic                  fifo_rd_ack,
    input  logic                  fifo_rd_err,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [CNT_WIDTH-1:0]  tmo_count
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    drain_state_t  state;
    drain_state_t  next_state;
    logic [TW-1:0] timer;
    logic          timer_last;
    logic          slot_free;
    logic          buf_push;
    logic          buf_pop;
    logic          buf_full;
    logic          err_inc;
    logic          tmo_inc;

    assign timer_last = (timer == TW'(ACK_TIMEOUT - 1));
    // A same-cycle pop frees a slot, so a full buffer being drained may still start a read.
    assign slot_free  = !buf_full || buf_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            fifo_rd <= 1'b0;
        end else begin
            state   <= next_state;
            fifo_rd <= (next_state == REQ);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (enable && !fifo_empty && slot_free) next_state = REQ;
            REQ:  if (fifo_rd_ack || fifo_rd_err || timer_last) next_state = GAP;
            GAP:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        buf_push = 1'b0;
        err_inc  = 1'b0;
        tmo_inc  = 1'b0;
        busy     = (state != IDLE);
        if (state == REQ) begin
            buf_push = fifo_rd_ack;
            err_inc  = !fifo_rd_ack && fifo_rd_err;
            tmo_inc  = !fifo_rd_ack && !fifo_rd_err && timer_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || state != REQ || next_state != REQ) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_stats) begin
            rd_count  <= '0;
            err_count <= '0;
            tmo_count <= '0;
        end else begin
            if (buf_push && rd_count != '1) rd_count  <= rd_count + CNT_WIDTH'(1);
            if (err_inc && err_count != '1) err_count <= err_count + CNT_WIDTH'(1);
            if (tmo_inc && tmo_count != '1) tmo_count <= tmo_count + CNT_WIDTH'(1);
        end
    end

    drain_out_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (buf_push),
        .push_data (fifo_dout),
        .ready     (m_ready),
        .valid     (m_valid),
        .data      (m_data),
        .pop       (buf_pop),
        .full      (buf_full)
    );

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb/tb_fifo_drain_ctrl.sv - scoreboard bench for fifo_drain_ctrl with a behavioural FIFO model
module tb_fifo_drain_ctrl;

    localparam int DW = 8;
    localparam int BD = 2;
    localparam int AT = 4;
    localparam int CW = 2;

    localparam int M_ACK  = 0;
    localparam int M_ERR  = 1;
    localparam int M_NONE = 2;
    localparam int M_BOTH = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          clr_stats;
    logic          fifo_empty;
    logic          fifo_rd_ack;
    logic          fifo_rd_err;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          busy;
    logic [CW-1:0] rd_count;
    logic [CW-1:0] err_count;
    logic [CW-1:0] tmo_count;

    int total = 0;
    int bad   = 0;
    int mode  = M_ACK;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];

    int hi_len, lo_len, pulses, last_hi, max_hi, min_gap;
    bit seen_pulse;

    fifo_drain_ctrl #(
        .DATA_WIDTH  (DW),
        .BUF_DEPTH   (BD),
        .ACK_TIMEOUT (AT),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .clr_stats   (clr_stats),
        .fifo_empty  (fifo_empty),
        .fifo_rd_ack (fifo_rd_ack),
        .fifo_rd_err (fifo_rd_err),
        .fifo_dout   (fifo_dout),
        .fifo_rd     (fifo_rd),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .busy        (busy),
        .rd_count    (rd_count),
        .err_count   (err_count),
        .tmo_count   (tmo_count)
    );

    always #5 clk = ~clk;

    // FIFO model: responds in the half cycle after rd rises, consumes the word once answered.
    always @(negedge clk) begin
        if ((fifo_rd_ack || fifo_rd_err) && fifo_q.size() > 0) void'(fifo_q.pop_front());
        fifo_rd_ack = fifo_rd && fifo_q.size() > 0 && (mode == M_ACK || mode == M_BOTH);
        fifo_rd_err = fifo_rd && fifo_q.size() > 0 && (mode == M_ERR || mode == M_BOTH);
        fifo_dout   = fifo_rd_ack ? fifo_q[0] : '0;
        fifo_empty  = (fifo_q.size() == 0);
    end

    always @(negedge clk) begin
        if (fifo_rd === 1'b1) begin
            if (hi_len == 0 && seen_pulse && lo_len < min_gap) min_gap = lo_len;
            hi_len++;
            lo_len = 0;
        end else begin
            if (hi_len > 0) begin
                pulses++;
                last_hi = hi_len;
                if (hi_len > max_hi) max_hi = hi_len;
                seen_pulse = 1'b1;
            end
            hi_len = 0;
            lo_len++;
        end
    end

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL stream_extra: got %0h expected no word", m_data);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    bad++;
                    $display("FAIL stream_data: got %0h expected %0h", m_data, e);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && dut.buf_push === 1'b1) begin
            total++;
            if (dut.buf_full !== 1'b0) begin
                bad++;
                $display("FAIL push_full: got full=%0b expected 0", dut.buf_full);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_trk();
        hi_len = 0; lo_len = 0; pulses = 0; last_hi = 0; max_hi = 0;
        min_gap = 1000; seen_pulse = 1'b0;
    endtask

    task automatic add_word(input logic [DW-1:0] w, input bit expect_out);
        fifo_q.push_back(w);
        if (expect_out) exp_q.push_back(w);
    endtask

    task automatic pulse_clr();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
    endtask

    task automatic wait_drained(input string name);
        for (int i = 0; i < 100 && !(fifo_q.size() == 0 && exp_q.size() == 0 && !busy); i++) tick();
        tick();
        chk(name, {fifo_q.size() == 0, exp_q.size() == 0, busy}, 3'b110);
    endtask

    task automatic wait_rd(input string name);
        for (int i = 0; i < 30 && fifo_rd !== 1'b1; i++) tick();
        chk(name, fifo_rd, 1'b1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 30 && busy !== 1'b0; i++) tick();
        tick();
        chk(name, busy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; clr_stats = 1'b0; m_ready = 1'b0;
        fifo_empty = 1'b1; fifo_rd_ack = 1'b0; fifo_rd_err = 1'b0; fifo_dout = '0;
        clear_trk();
        repeat (3) tick();
        chk("rst_fifo_rd", fifo_rd, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_counts", {rd_count, err_count, tmo_count}, 6'h0);
        rst_n = 1'b1;
        tick();

        // Basic drain
        mode = M_ACK; m_ready = 1'b1;
        add_word(8'h11, 1); add_word(8'h22, 1); add_word(8'h33, 1);
        clear_trk();
        enable = 1'b1;
        wait_drained("t1_drained");
        chk("t1_pulses", pulses, 3);
        chk("t1_pulse_len", max_hi, 1);
        chk("t1_gap_ok", min_gap >= 1, 1);
        chk("t1_rd_count", rd_count, 3);

        // Backpressure, then release; 5 reads also saturate the 2-bit counter
        enable = 1'b0; pulse_clr();
        m_ready = 1'b0;
        add_word(8'hA1, 1); add_word(8'hA2, 1); add_word(8'hA3, 1);
        add_word(8'hA4, 1); add_word(8'hA5, 1);
        clear_trk();
        enable = 1'b1;
        repeat (30) tick();
        chk("t2_pulses_held", pulses, 2);
        chk("t2_fifo_rd_low", fifo_rd, 1'b0);
        chk("t2_m_valid", m_valid, 1'b1);
        chk("t2_m_data_head", m_data, 8'hA1);
        chk("t2_fifo_left", fifo_q.size(), 3);
        m_ready = 1'b1;
        wait_drained("t2_drained");
        chk("t2_pulses_all", pulses, 5);
        chk("t2_rd_count_sat", rd_count, 3);

        // Ack timeout
        enable = 1'b0; pulse_clr();
        mode = M_NONE;
        add_word(8'h77, 0);
        clear_trk();
        enable = 1'b1;
        wait_rd("t3_rd_start");
        chk("t3_busy", busy, 1'b1);
        enable = 1'b0;
        wait_idle("t3_idle");
        chk("t3_rd_high_len", last_hi, AT);
        chk("t3_tmo_count", tmo_count, 1);
        chk("t3_rd_count", rd_count, 0);
        chk("t3_m_valid", m_valid, 1'b0);
        fifo_q.delete();

        // Read error, then ack+err together
        mode = M_ERR;
        add_word(8'h55, 0);
        clear_trk();
        enable = 1'b1;
        wait_rd("t4_rd_start");
        enable = 1'b0;
        wait_idle("t4_idle");
        chk("t4_err_count", err_count, 1);
        chk("t4_no_push", m_valid, 1'b0);
        chk("t4_pulse_len", last_hi, 1);
        mode = M_BOTH;
        add_word(8'h66, 1);
        enable = 1'b1;
        wait_rd("t4b_rd_start");
        enable = 1'b0;
        wait_drained("t4b_drained");
        chk("t4b_rd_count", rd_count, 1);
        chk("t4b_err_count", err_count, 1);

        // Reset while a read is pending
        mode = M_NONE;
        add_word(8'h99, 0);
        enable = 1'b1;
        wait_rd("t5_rd_start");
        rst_n = 1'b0;
        tick();
        chk("t5_fifo_rd", fifo_rd, 1'b0);
        chk("t5_m_valid", m_valid, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_counts", {rd_count, err_count, tmo_count}, 6'h0);
        enable = 1'b0; rst_n = 1'b1;
        fifo_q.delete();
        tick();

        // Saturation, then clr_stats on the same edge as an ack
        mode = M_ACK;
        for (int i = 0; i < 5; i++) add_word(8'hC0 + 8'(i), 1);
        enable = 1'b1;
        wait_drained("t6_drained");
        chk("t6_rd_count_sat", rd_count, 3);
        enable = 1'b0;
        add_word(8'hD7, 1);
        tick();
        enable = 1'b1;
        wait_rd("t6_rd_start");
        clr_stats = 1'b1; enable = 1'b0;
        tick();
        clr_stats = 1'b0;
        chk("t6_clr_wins", rd_count, 0);
        wait_drained("t6b_drained");
        chk("t6_rd_count_after", rd_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_drain_ctrl.md
Name: fifo_drain_ctrl

Overview:
- Clocked read-side master placed directly downstream of the async FIFO.
- Pulses the FIFO `rd` strobe when data is available and qualifies each read with `rd_ack`/`rd_err`.
- Captures `fifo_dout` into a 2-entry output buffer and presents it on a valid/ready stream to the consumer.
- Keeps saturating statistics counters for reads, read errors and ack timeouts.

Parameters:
- DATA_WIDTH, 8: FIFO data width and stream data width.
- BUF_DEPTH, 2: output buffer entries; legal values are 2 or 4.
- ACK_TIMEOUT, 4: cycles `rd` is held high waiting for `rd_ack`/`rd_err` before abandoning the read; must be ≥1.
- CNT_WIDTH, 16: width of each statistics counter.

Ports:
- clk  in  1  block clock.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  when 0, no new read is started; an in-flight read completes.
- clr_stats  in  1  synchronous clear of all three counters.
- fifo_empty  in  1  FIFO `empty` flag.
- fifo_rd_ack  in  1  FIFO `rd_ack`.
- fifo_rd_err  in  1  FIFO `rd_err`.
- fifo_dout  in  DATA_WIDTH  FIFO read data; valid only while `fifo_rd_ack` is 1.
- fifo_rd  out  1  FIFO read strobe (registered).
- m_valid  out  1  output buffer non-empty.
- m_data  out  DATA_WIDTH  head of output buffer.
- m_ready  in  1  consumer accepts `m_data` when `m_valid & m_ready`.
- busy  out  1  FSM not in IDLE.
- rd_count  out  CNT_WIDTH  successful reads.
- err_count  out  CNT_WIDTH  `rd_err` events.
- tmo_count  out  CNT_WIDTH  ack timeouts.

Behaviour:
- Reset (clk edge with rst_n=0):
  - state=IDLE; `fifo_rd`=0; buffer emptied, so `m_valid`=0 and `m_data`=0.
  - ack timer=0; all counters=0; `busy`=0.
  - Reset mid-REQ drops `fifo_rd` at that edge and discards the pending read.
- The FIFO reacts to `rd` level changes, so `fifo_rd` must return to 0 for at least one cycle between reads.
- FSM states: IDLE, REQ, GAP.
  - IDLE: `fifo_rd`=0.
    - Go to REQ and register `fifo_rd`=1 when `enable` & !`fifo_empty` & buffer count<BUF_DEPTH.
    - Free-slot check uses the count after any same-cycle pop.
  - REQ: `fifo_rd`=1. Sample the FIFO responses at each edge; if both ack and err are 1, ack wins.
    - `fifo_rd_ack`=1: push `fifo_dout` into the buffer, increment `rd_count`, go to GAP.
    - else `fifo_rd_err`=1: increment `err_count`, no push, go to GAP.
    - else timer==ACK_TIMEOUT-1: increment `tmo_count`, no push, go to GAP.
    - else: timer+1, stay in REQ.
  - GAP: `fifo_rd`=0, timer=0, then go to IDLE unconditionally.
- Minimum read period is 3 cycles (IDLE→REQ→GAP).
- `fifo_rd_ack`/`fifo_rd_err` outside REQ are ignored and not counted.
- Output buffer:
  - Circular, first-in first-out.
  - Pop on `m_valid & m_ready`.
  - Push and pop in the same cycle are both allowed; count is unchanged.
  - `m_data` is stable while `m_valid` & !`m_ready`.
  - Pushing when full cannot occur by construction; verification checks this with an assertion.
- Counters:
  - Saturate at 2^CNT_WIDTH-1; no wrap.
  - `clr_stats` has priority over an increment in the same cycle.
- `enable` deasserted during REQ/GAP: the current read finishes normally, then the FSM stays in IDLE.
- `fifo_empty` rising during REQ: no abort; the FIFO's ack/err/timeout decides the outcome.
- Latency: FIFO ack sampled at edge N → `m_valid`=1 after edge N, provided the buffer was empty.

Decomposition:
- fifo_drain_pkg:
  - state enum `drain_state_t` {IDLE, REQ, GAP};
  - default constants DATA_WIDTH_D=8, BUF_DEPTH_D=2, ACK_TIMEOUT_D=4, CNT_WIDTH_D=16.
- Sub-module `drain_out_buf`:
  - parameterized BUF_DEPTH-entry valid/ready buffer with push, pop, count and full.
  - The FSM, timer and counters remain in the top level.

Test Plan:
- Basic drain:
  - Stimulus: model FIFO holds 0x11, 0x22, 0x33, returns `rd_ack` in the REQ cycle; `m_ready`=1.
  - Response: `m_data` sequence 0x11, 0x22, 0x33; three `fifo_rd` pulses, each 1 cycle high with ≥1 cycle low between; `rd_count`=3.
- Backpressure:
  - Stimulus: 5 words queued, `m_ready`=0.
  - Response: exactly 2 reads issued, buffer full, `fifo_rd` stays 0.
  - Then: raise `m_ready`; all 5 words arrive in order and no word is lost.
- Timeout:
  - Stimulus: model never acks with ACK_TIMEOUT=4.
  - Response: `fifo_rd` high for 4 cycles, then low; `tmo_count`=1; `m_valid`=0.
- Read error:
  - Stimulus: model answers `rd_err`=1.
  - Response: `err_count`=1, no push, FSM returns to IDLE via GAP.
  - Also: ack and err asserted together → treated as ack.
- Reset mid-REQ:
  - Stimulus: `rst_n`=0 while `fifo_rd`=1.
  - Response: next edge gives `fifo_rd`=0, `m_valid`=0, all counters 0, `busy`=0.
- Saturation:
  - Stimulus: CNT_WIDTH=2 with 5 successful reads.
  - Response: `rd_count` holds 3.
  - Then: `clr_stats` pulse coinciding with an ack → `rd_count`=0.
